// File: rtl/ecc_secded_pkg.sv
// SECDED code helpers: code sizing, encode, syndrome and decode.
// The helpers work on a MAX_DW-wide zero-extended data field.
package ecc_secded_pkg;

    localparam int unsigned MAX_DW = 128;
    localparam int unsigned MAX_P  = 9;
    localparam int unsigned SYN_W  = MAX_P - 1;

    typedef struct packed {
        logic [MAX_DW-1:0] data;
        logic              corr;
        logic              uncorr;
    } dec_res_t;

    function automatic int unsigned calc_parity_w(input int unsigned dw);
        int unsigned r;
        r = 1;
        for (int unsigned k = 0; k < SYN_W; k++) begin
            if ((32'd1 << r) < dw + r + 1) r = r + 1;
        end
        return r + 1;
    endfunction

    // Hamming position of data bit i: skip every power-of-two slot at or below it.
    function automatic int unsigned data_pos(input int unsigned i);
        int unsigned p;
        p = i + 1;
        for (int unsigned j = 0; j < SYN_W; j++) begin
            if ((32'd1 << j) <= p) p = p + 1;
        end
        return p;
    endfunction

    function automatic logic [SYN_W-1:0] hamming_xor(input logic [MAX_DW-1:0] data,
                                                     input int unsigned dw);
        logic [SYN_W-1:0] s;
        s = '0;
        for (int unsigned i = 0; i < MAX_DW; i++) begin
            if (i < dw && data[i]) s = s ^ SYN_W'(data_pos(i));
        end
        return s;
    endfunction

    // Check vector: bits [r-1:0] are the Hamming bits, bit r the overall parity.
    function automatic logic [MAX_P-1:0] secded_encode(input logic [MAX_DW-1:0] data,
                                                       input int unsigned dw);
        int unsigned      r;
        logic [MAX_P-1:0] chk;
        r   = calc_parity_w(dw) - 1;
        chk = '0;
        chk[SYN_W-1:0] = hamming_xor(data, dw);
        chk[r] = (^data) ^ (^chk);
        return chk;
    endfunction

    // Returns {overall parity error, Hamming syndrome}.
    function automatic logic [MAX_P-1:0] secded_syndrome(input logic [MAX_DW-1:0] data,
                                                         input logic [MAX_P-1:0]  chk,
                                                         input int unsigned       dw);
        int unsigned      r;
        logic [SYN_W-1:0] hmask;
        logic [SYN_W-1:0] syn;
        r     = calc_parity_w(dw) - 1;
        hmask = SYN_W'((32'd1 << r) - 1);
        syn   = hamming_xor(data, dw) ^ (chk[SYN_W-1:0] & hmask);
        return {(^data) ^ (^chk), syn};
    endfunction

    function automatic dec_res_t secded_decode(input logic [MAX_DW-1:0] data,
                                               input logic [MAX_P-1:0]  chk,
                                               input int unsigned       dw);
        dec_res_t         res;
        logic [MAX_P-1:0] sf;
        logic [SYN_W-1:0] syn;
        sf         = secded_syndrome(data, chk, dw);
        syn        = sf[SYN_W-1:0];
        res.data   = data;
        res.corr   = 1'b0;
        res.uncorr = 1'b0;
        if (sf[SYN_W]) begin
            res.corr = 1'b1;
            for (int unsigned i = 0; i < MAX_DW; i++) begin
                if (i < dw && data_pos(i) == {{(32-SYN_W){1'b0}}, syn}) res.data[i] = ~data[i];
            end
        end else if (syn != '0) begin
            res.uncorr = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/ecc_secded_dec.sv
// Combinational SECDED decoder for one stored codeword {check, data}.
module ecc_secded_dec
    import ecc_secded_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned P      = calc_parity_w(DATA_W)
) (
    input  logic [DATA_W+P-1:0] cw,
    output logic [DATA_W-1:0]   data,
    output logic                corr,
    output logic                uncorr
);

    logic [MAX_DW-1:0] data_ext;
    logic [MAX_P-1:0]  chk_ext;
    dec_res_t          res;
    logic              unused_res;

    always_comb begin
        data_ext = '0;
        chk_ext  = '0;
        data_ext[DATA_W-1:0] = cw[DATA_W-1:0];
        chk_ext[P-1:0]       = cw[DATA_W+P-1:DATA_W];
    end

    assign res        = secded_decode(data_ext, chk_ext, DATA_W);
    assign data       = res.data[DATA_W-1:0];
    assign corr       = res.corr;
    assign uncorr     = res.uncorr;
    assign unused_res = ^res.data;

endmodule

// File: rtl/ecc_secded_fifo.sv
// Synchronous FIFO storing SECDED-encoded words, corrected on pop, with error counters.
// Optional macro ECC_SECDED_FIFO_FAULT_INJ_EN adds inj_en/inj_mask fault-injection ports.
module ecc_secded_fifo
    import ecc_secded_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_err_corr,
    output logic                       rd_err_uncorr,
    output logic [$clog2(DEPTH):0]     count,
    input  logic                       clr_cnt,
    output logic [CNT_W-1:0]           corr_cnt,
    output logic [CNT_W-1:0]           uncorr_cnt,
    output logic [$clog2(DEPTH)-1:0]   err_addr
`ifdef ECC_SECDED_FIFO_FAULT_INJ_EN
    ,
    input  logic                                 inj_en,
    input  logic [DATA_W+calc_parity_w(DATA_W)-1:0] inj_mask
`endif
);

    localparam int unsigned P  = calc_parity_w(DATA_W);
    localparam int unsigned CW = DATA_W + P;
    localparam int unsigned AW = $clog2(DEPTH);

    logic [CW-1:0]     mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       occ;
    logic              push, pop;
    logic [MAX_DW-1:0] wr_ext;
    logic [MAX_P-1:0]  wr_chk;
    logic [CW-1:0]     wr_cw;
    logic              unused_chk;
    logic [DATA_W-1:0] head_data;
    logic              head_corr, head_uncorr;
    logic [CNT_W-1:0]  corr_base, uncorr_base, corr_nxt, uncorr_nxt;
    logic [AW-1:0]     addr_nxt;

    assign wr_ready = (occ != (AW+1)'(DEPTH));
    assign rd_valid = (occ != '0);
    assign push     = wr_valid && wr_ready;
    assign pop      = rd_valid && rd_ready;
    assign count    = occ;

    always_comb begin
        wr_ext = '0;
        wr_ext[DATA_W-1:0] = wr_data;
        wr_chk = secded_encode(wr_ext, DATA_W);
        wr_cw  = {wr_chk[P-1:0], wr_data};
`ifdef ECC_SECDED_FIFO_FAULT_INJ_EN
        if (inj_en) wr_cw = wr_cw ^ inj_mask;
`endif
    end
    assign unused_chk = ^wr_chk;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_cw;
    end

    // Pointers wrap naturally at the power-of-two depth; full/empty come from occ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      occ <= occ + 1'b1;
            else if (pop && !push) occ <= occ - 1'b1;
        end
    end

    ecc_secded_dec #(
        .DATA_W (DATA_W),
        .P      (P)
    ) u_dec (
        .cw     (mem[rd_ptr]),
        .data   (head_data),
        .corr   (head_corr),
        .uncorr (head_uncorr)
    );

    assign rd_data       = rd_valid ? head_data : '0;
    assign rd_err_corr   = rd_valid & head_corr;
    assign rd_err_uncorr = rd_valid & head_uncorr;

    // A clear in the same cycle as an erroring pop lands first, then the event counts.
    always_comb begin
        corr_base   = clr_cnt ? '0 : corr_cnt;
        uncorr_base = clr_cnt ? '0 : uncorr_cnt;
        addr_nxt    = clr_cnt ? '0 : err_addr;
        corr_nxt    = corr_base;
        uncorr_nxt  = uncorr_base;
        if (pop && head_corr) begin
            corr_nxt = (&corr_base) ? corr_base : corr_base + 1'b1;
            addr_nxt = rd_ptr;
        end
        if (pop && head_uncorr) begin
            uncorr_nxt = (&uncorr_base) ? uncorr_base : uncorr_base + 1'b1;
            addr_nxt   = rd_ptr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
            err_addr   <= '0;
        end else begin
            corr_cnt   <= corr_nxt;
            uncorr_cnt <= uncorr_nxt;
            err_addr   <= addr_nxt;
        end
    end

endmodule

// File: tb/tb_ecc_secded_fifo.sv
// Self-checking bench for ecc_secded_fifo: vector table, corner sequences, random traffic.
module tb_ecc_secded_fifo;

    localparam int DW    = 64;
    localparam int DEPTH = 16;
    localparam int CNT_W = 4;
    localparam int CW    = 72;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_valid, wr_ready, rd_valid, rd_ready;
    logic          rd_err_corr, rd_err_uncorr, clr_cnt;
    logic [DW-1:0] wr_data, rd_data;
    logic [4:0]    count;
    logic [3:0]    corr_cnt, uncorr_cnt, err_addr;
`ifdef ECC_SECDED_FIFO_FAULT_INJ_EN
    logic          inj_en;
    logic [CW-1:0] inj_mask;
`endif

    always #5 clk = ~clk;

    ecc_secded_fifo #(
        .DATA_W (DW),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_data       (wr_data),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_data       (rd_data),
        .rd_err_corr   (rd_err_corr),
        .rd_err_uncorr (rd_err_uncorr),
        .count         (count),
        .clr_cnt       (clr_cnt),
        .corr_cnt      (corr_cnt),
        .uncorr_cnt    (uncorr_cnt),
        .err_addr      (err_addr)
`ifdef ECC_SECDED_FIFO_FAULT_INJ_EN
        ,
        .inj_en        (inj_en),
        .inj_mask      (inj_mask)
`endif
    );

    // Reference model: queue of pushed words with the corruption applied to each.
    typedef struct {
        logic [DW-1:0] data;
        logic [CW-1:0] mask;
        int            idx;
    } entry_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [CW-1:0] mask;
        logic [DW-1:0] exp_data;
        logic          exp_corr;
        logic          exp_uncorr;
    } vec_t;

    entry_t q[$];
    vec_t   vecs[7];
    int     m_wr, m_corr, m_uncorr, m_addr;
    int     checks = 0;
    int     failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, want);
        end
    endtask

    // One flipped bit is corrected; two flipped bits are reported with raw data.
    function automatic void head_exp(input entry_t e, output logic [DW-1:0] d,
                                     output logic c, output logic u);
        int n;
        n = $countones(e.mask);
        c = (n == 1);
        u = (n == 2);
        d = (n == 2) ? (e.data ^ e.mask[DW-1:0]) : e.data;
    endfunction

    task automatic model_reset();
        q.delete();
        m_wr = 0; m_corr = 0; m_uncorr = 0; m_addr = 0;
    endtask

    task automatic check_all();
        logic [DW-1:0] d;
        logic          c, u;
        d = '0; c = 1'b0; u = 1'b0;
        chk("wr_ready", 128'(wr_ready), 128'(q.size() < DEPTH));
        chk("rd_valid", 128'(rd_valid), 128'(q.size() != 0));
        chk("count", 128'(count), 128'(q.size()));
        if (q.size() != 0) head_exp(q[0], d, c, u);
        chk("rd_data", 128'(rd_data), 128'(d));
        chk("rd_err_corr", 128'(rd_err_corr), 128'(c));
        chk("rd_err_uncorr", 128'(rd_err_uncorr), 128'(u));
        chk("corr_cnt", 128'(corr_cnt), 128'(m_corr));
        chk("uncorr_cnt", 128'(uncorr_cnt), 128'(m_uncorr));
        chk("err_addr", 128'(err_addr), 128'(m_addr));
    endtask

    task automatic step(input logic wv, input logic [DW-1:0] wd, input logic [CW-1:0] mask,
                        input logic rr, input logic clr);
        bit     do_push, do_pop;
        int     widx, n;
        entry_t e;
        wr_valid = wv; wr_data = wd; rd_ready = rr; clr_cnt = clr;
`ifdef ECC_SECDED_FIFO_FAULT_INJ_EN
        inj_en = (mask != '0); inj_mask = mask;
`endif
        do_push = wv && (q.size() < DEPTH);
        do_pop  = rr && (q.size() > 0);
        widx    = m_wr;
        @(posedge clk);
        #1;
        if (clr) begin m_corr = 0; m_uncorr = 0; m_addr = 0; end
        if (do_pop) begin
            e = q.pop_front();
            n = $countones(e.mask);
            if (n == 1) begin m_corr = (m_corr == CMAX) ? CMAX : m_corr + 1; m_addr = e.idx; end
            if (n == 2) begin m_uncorr = (m_uncorr == CMAX) ? CMAX : m_uncorr + 1; m_addr = e.idx; end
        end
        if (do_push) begin
            q.push_back('{data: wd, mask: mask, idx: widx});
            m_wr = (m_wr + 1) % DEPTH;
`ifndef ECC_SECDED_FIFO_FAULT_INJ_EN
            if (mask != '0) dut.mem[widx] = dut.mem[widx] ^ mask;
`endif
        end
        wr_valid = 1'b0; rd_ready = 1'b0; clr_cnt = 1'b0;
`ifdef ECC_SECDED_FIFO_FAULT_INJ_EN
        inj_en = 1'b0;
`endif
        #1;
        check_all();
    endtask

    initial begin
        logic [CW-1:0] m;
        int            b1, saved_idx;

        vecs[0] = '{64'hA5A5_A5A5_A5A5_A5A5, 72'h1 << 5, 64'hA5A5_A5A5_A5A5_A5A5, 1'b1, 1'b0};
        vecs[1] = '{64'hA5A5_A5A5_A5A5_A5A5, (72'h1 << 3) | (72'h1 << 40),
                    64'hA5A5_A4A5_A5A5_A5AD, 1'b0, 1'b1};
        vecs[2] = '{64'h0123_4567_89AB_CDEF, 72'h1 << 71, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0};
        vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 72'h1 << 64, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
        vecs[4] = '{64'h0, 72'h0, 64'h0, 1'b0, 1'b0};
        vecs[5] = '{64'h8000_0000_0000_0000, (72'h1 << 63) | (72'h1 << 71), 64'h0, 1'b0, 1'b1};
        vecs[6] = '{64'h1234, (72'h1 << 65) | (72'h1 << 66), 64'h1234, 1'b0, 1'b1};

        rst_n = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0; clr_cnt = 1'b0; wr_data = '0;
`ifdef ECC_SECDED_FIFO_FAULT_INJ_EN
        inj_en = 1'b0; inj_mask = '0;
`endif
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all();

        step(1'b1, 64'hDEAD_BEEF_0123_4567, '0, 1'b0, 1'b0);
        chk("first_count", 128'(count), 128'd1);
        chk("first_data", 128'(rd_data), 128'(64'hDEAD_BEEF_0123_4567));
        step(1'b0, '0, '0, 1'b1, 1'b0);
        chk("first_empty", 128'(count), 128'd0);

        for (int i = 0; i < 7; i++) begin
            saved_idx = m_wr;
            step(1'b1, vecs[i].data, vecs[i].mask, 1'b0, 1'b0);
            chk("vec_data", 128'(rd_data), 128'(vecs[i].exp_data));
            chk("vec_corr", 128'(rd_err_corr), 128'(vecs[i].exp_corr));
            chk("vec_uncorr", 128'(rd_err_uncorr), 128'(vecs[i].exp_uncorr));
            step(1'b0, '0, '0, 1'b1, 1'b0);
            if (i == 0) begin
                chk("vec0_corr_cnt", 128'(corr_cnt), 128'd1);
                chk("vec0_err_addr", 128'(err_addr), 128'(saved_idx));
            end
            if (i == 1) chk("vec1_uncorr_cnt", 128'(uncorr_cnt), 128'd1);
        end

        for (int v = 0; v <= DEPTH; v++) step(1'b1, 64'(v), '0, 1'b0, 1'b0);
        chk("full_count", 128'(count), 128'(DEPTH));
        chk("full_ready", 128'(wr_ready), 128'd0);
        for (int v = 0; v < DEPTH; v++) begin
            chk("order_data", 128'(rd_data), 128'(v));
            step(1'b0, '0, '0, 1'b1, 1'b0);
        end
        for (int v = 0; v < 20; v++) step(1'b1, 64'(100 + v), '0, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);

        for (int v = 0; v < 3; v++) step(1'b1, 64'(v + 7), 72'h1 << (v * 9), 1'b0, 1'b0);
        for (int v = 0; v < 3; v++) begin
            step(1'b0, '0, '0, 1'b1, 1'b1);
            chk("clr_pop_corr_cnt", 128'(corr_cnt), 128'd1);
        end

        step(1'b1, 64'h55, '0, 1'b0, 1'b0);
        step(1'b1, 64'h66, '0, 1'b1, 1'b0);
        chk("pushpop_count", 128'(count), 128'd1);
        chk("pushpop_data", 128'(rd_data), 128'h66);
        step(1'b0, '0, '0, 1'b1, 1'b0);

        step(1'b0, '0, '0, 1'b0, 1'b1);
        step(1'b1, 64'h77, 72'h1 << 7, 1'b0, 1'b0);
        for (int v = 0; v < (1 << CNT_W) + 2; v++) step(1'b1, 64'(v), 72'h1 << 7, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        chk("sat_corr_cnt", 128'(corr_cnt), 128'(CMAX));

        for (int n = 0; n < 400; n++) begin
            m = '0;
            b1 = $urandom_range(0, CW - 1);
            case ($urandom_range(0, 5))
                0: m[b1] = 1'b1;
                1: begin m[b1] = 1'b1; m[(b1 + $urandom_range(1, CW - 1)) % CW] = 1'b1; end
                default: m = '0;
            endcase
            step($urandom_range(0, 3) != 0, {$urandom, $urandom}, m,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
        end

        for (int v = 0; v < 5; v++) step(1'b1, 64'(v), 72'h1 << 2, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 64'hCAFE, '0, 1'b0, 1'b0);
        chk("post_reset_data", 128'(rd_data), 128'hCAFE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
